// File: rtl/traffic_sched_pkg.sv
// Shared types for the intersection phase scheduler:
// phase state encodings, owner indices and the owner one-hot helper.
package traffic_sched_pkg;

    typedef enum logic [1:0] {
        FLASH   = 2'd0,
        ALL_RED = 2'd1,
        GREEN   = 2'd2,
        YELLOW  = 2'd3
    } state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t NS  = 2'd0;
    localparam owner_t EW  = 2'd1;
    localparam owner_t PED = 2'd2;

    // Index 3 is not a legal owner and maps to an empty mask.
    function automatic logic [2:0] owner_mask(input owner_t o);
        return 3'b001 << o;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_rr_pick3.sv
// Round-robin search for the next right-of-way owner:
// cur+1, cur+2, then cur; NS when nothing is pending.
module rr_pick3
    import traffic_sched_pkg::*;
(
    input  logic [2:0] pending,
    input  owner_t     cur,
    output owner_t     nxt
);

    owner_t c0;
    owner_t c1;
    owner_t c2;

    always_comb begin
        c1 = EW;
        c2 = PED;
        c0 = NS;
        case (cur)
            EW: begin
                c1 = PED;
                c2 = NS;
                c0 = EW;
            end
            PED: begin
                c1 = NS;
                c2 = EW;
                c0 = PED;
            end
            default: ;
        endcase

        nxt = NS;
        if (|(pending & owner_mask(c1)))
            nxt = c1;
        else if (|(pending & owner_mask(c2)))
            nxt = c2;
        else if (|(pending & owner_mask(c0)))
            nxt = c0;
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Right-of-way scheduler for NS/EW/PED with GREEN-YELLOW-ALL_RED clearance.
// Define PREEMPT_EN to add the emergency preempt input toward NS.
module intersection_phase_scheduler
    import traffic_sched_pkg::*;
#(
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_PED       = 10,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int TW          = 5
) (
    input  logic          clk_1Hz,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [2:0]    req,
`ifdef PREEMPT_EN
    input  logic          preempt,
`endif
    output logic [2:0]    grant,
    output logic          yellow_o,
    output logic          all_red_o,
    output logic          flash_o,
    output logic [2:0]    served,
    output logic [TW-1:0] remaining
);

    localparam logic [TW-1:0] LD_MIN = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] LD_MAX = TW'(T_MAX_GREEN - 1);
    localparam logic [TW-1:0] LD_PED = TW'(T_PED - 1);
    localparam logic [TW-1:0] LD_YEL = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] LD_AR  = TW'(T_ALL_RED - 1);
    localparam logic [TW-1:0] EL_SAT = '1;

    state_t        state;
    state_t        state_n;
    owner_t        cur;
    owner_t        cur_n;
    owner_t        pick;
    owner_t        nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [TW-1:0] elapsed;
    logic [TW-1:0] elapsed_n;
    logic [2:0]    pending;
    logic [2:0]    pending_n;
    logic [2:0]    served_n;
    logic [2:0]    cur_mask;
    logic [2:0]    others;
    logic          stop;
    logic          stop_n;
    logic          expired;
    logic          rest;

    rr_pick3 u_pick (
        .pending (pending),
        .cur     (cur),
        .nxt     (pick)
    );

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        timer_n   = timer;
        elapsed_n = elapsed;
        stop_n    = stop;
        served_n  = 3'b000;
        cur_mask  = owner_mask(cur);
        others    = pending & ~cur_mask;
        expired   = (timer == '0);
        nxt       = pick;
        rest      = (cur == NS) && (others == 3'b000);
`ifdef PREEMPT_EN
        if (preempt)
            nxt = NS;
        if (preempt && cur == NS)
            rest = 1'b1;
`endif
        // The current owner cannot re-request itself while it is green.
        pending_n = pending
                  | (req & ~((state == GREEN) ? cur_mask : 3'b000));

        unique case (state)
            FLASH: begin
                if (enable) begin
                    state_n = ALL_RED;
                    timer_n = LD_AR;
                    stop_n  = 1'b0;
                end
            end
            ALL_RED: begin
                if (!enable)
                    stop_n = 1'b1;
                if (!expired) begin
                    timer_n = timer - 1'b1;
                end else if (stop || !enable) begin
                    state_n = FLASH;
                    timer_n = '0;
                end else begin
                    state_n   = GREEN;
                    cur_n     = nxt;
                    elapsed_n = '0;
                    served_n  = owner_mask(nxt);
                    pending_n = pending_n & ~owner_mask(nxt);
                    timer_n   = (nxt == PED) ? LD_PED : LD_MAX;
                end
            end
            GREEN: begin
                if (elapsed != EL_SAT)
                    elapsed_n = elapsed + 1'b1;
                if (!enable) begin
                    stop_n  = 1'b1;
                    state_n = YELLOW;
                    timer_n = LD_YEL;
`ifdef PREEMPT_EN
                end else if (preempt && cur != NS) begin
                    state_n = YELLOW;
                    timer_n = LD_YEL;
`endif
                end else if (rest) begin
                    timer_n = timer;
                end else if (expired
                        || (cur != PED && elapsed >= LD_MIN
                            && others != 3'b000)) begin
                    state_n = YELLOW;
                    timer_n = LD_YEL;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            YELLOW: begin
                if (!enable)
                    stop_n = 1'b1;
                if (expired) begin
                    state_n = ALL_RED;
                    timer_n = LD_AR;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            state     <= FLASH;
            cur       <= NS;
            timer     <= '0;
            elapsed   <= '0;
            pending   <= 3'b000;
            stop      <= 1'b0;
            grant     <= 3'b000;
            yellow_o  <= 1'b0;
            all_red_o <= 1'b0;
            flash_o   <= 1'b1;
            served    <= 3'b000;
            remaining <= '0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            timer     <= timer_n;
            elapsed   <= elapsed_n;
            pending   <= pending_n;
            stop      <= stop_n;
            grant     <= (state_n == GREEN) ? owner_mask(cur_n) : 3'b000;
            yellow_o  <= (state_n == YELLOW);
            all_red_o <= (state_n == ALL_RED);
            flash_o   <= (state_n == FLASH);
            served    <= served_n;
            remaining <= (state_n == FLASH) ? '0 : timer_n;
        end
    end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Right-of-way scheduler for one intersection with three requesters: north-south vehicles (NS, home phase), east-west vehicles (EW) and the pedestrian crossing (PED). It latches requests, picks the next owner round-robin, and sequences GREEN → YELLOW → ALL_RED clearance with minimum and maximum green limits. It sits between the push-button/detector front end and the lamp and countdown-display outputs.

## Interface
- T_MIN_GREEN, 5, minimum vehicle green in ticks before gap-out
- T_MAX_GREEN, 20, maximum EW green in ticks
- T_PED, 10, fixed pedestrian walk in ticks
- T_YELLOW, 3, clearance ticks after any green or walk
- T_ALL_RED, 2, all-red ticks before every grant
- TW, 5, timer width; every T_* parameter must be ≤ 2^TW
- clk_1Hz  in  1  tick clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  0 = go dark (flash) after orderly clearance
- req  in  3  level requests: [0]=NS, [1]=EW, [2]=PED
- preempt  in  1  emergency preemption toward NS (only with PREEMPT_EN)
- grant  out  3  one-hot current green/walk owner; 0 outside GREEN
- yellow_o  out  1  high in YELLOW
- all_red_o  out  1  high in ALL_RED
- flash_o  out  1  high in FLASH
- served  out  3  one-tick pulse on the grant-start tick of that owner
- remaining  out  TW  current timer value; 0 in FLASH

## Operation
- States: FLASH, ALL_RED, GREEN, YELLOW. Registers: state, cur (owner), timer, elapsed, pending[2:0], stop (pending flash).
- Reset: state=FLASH, cur=NS, pending=0, timer=0, elapsed=0, stop=0. Outputs: flash_o=1, all other outputs 0.
- Timers load duration−1 and decrement once per tick, so a state lasts exactly its duration. Expiry condition is timer==0.
- Latching: pending[i] is set when req[i]=1, except for i==cur while state is GREEN. On the grant-start tick, pending[cur] is cleared; clear wins over a simultaneous set.
- FLASH: stays while enable=0. With enable=1, goes to ALL_RED and clears stop.
- ALL_RED on expiry:
  - stop=1 → FLASH.
  - Otherwise go to GREEN with nxt = the first pending owner in order cur+1, cur+2, cur (mod 3). If nothing is pending, nxt = NS.
  - Set cur=nxt, elapsed=0, pulse served[nxt].
  - Timer loads T_PED−1 for PED, otherwise T_MAX_GREEN−1.
- GREEN, with elapsed saturating at 2^TW−1:
  - NS with no other owner pending: rests. Timer is held and never expires.
  - Vehicle owner: goes to YELLOW when timer==0, or when elapsed ≥ T_MIN_GREEN−1 and another owner is pending.
  - PED: goes to YELLOW only on timer==0.
  - enable=0: goes to YELLOW next tick (regardless of min green) and sets stop.
- YELLOW: grant=0. On expiry → ALL_RED. enable=0 during YELLOW or ALL_RED sets stop; the sequence completes, then enters FLASH.
- remaining shows the timer in all states except FLASH. During NS rest it shows the held value T_MAX_GREEN−1.

## Timing
- All outputs are registered and change only on clk_1Hz edges.
- Grant latency from reset release with enable=1: ALL_RED ticks 1–2, NS green from tick 3.
- Minimal NS→EW handover: request seen at tick t with elapsed ≥ 4 → YELLOW t+1..t+3, ALL_RED t+4..t+5, EW grant at t+6.
- rst_n low mid-operation: returns to the reset state on the next edge. Pending requests are lost.

## Configuration
- PREEMPT_EN defined:
  - The preempt port exists.
  - preempt=1 in GREEN with cur≠NS → YELLOW next tick, ignoring min green.
  - ALL_RED expiry forces nxt=NS.
  - NS green holds without gap-out while preempt=1. Ignored in FLASH.
- PREEMPT_EN undefined: no preempt port and no preemption logic. Behaviour is exactly as in Operation.

## Structure
- Shared package traffic_sched_pkg holds:
  - state encodings: FLASH=0, ALL_RED=1, GREEN=2, YELLOW=3
  - owner indices: NS=0, EW=1, PED=2
- One combinational sub-module, rr_pick3 (inputs pending and cur; output nxt), holds the round-robin search.

## Test plan
- Reset, then enable=1, no requests → all_red_o ticks 1–2, grant=001 from tick 3 with served[0] pulse, rest indefinitely with remaining=19.
- NS rest ≥5 ticks, req[1] pulse → yellow_o 3 ticks, all_red_o 2 ticks, grant=010 and served[1]; with no other requests, EW holds 20 ticks, then returns to NS.
- req[2] at EW elapsed=1 → EW gaps out at elapsed=4, then 3 yellow + 2 all-red, grant=100 for exactly 10 ticks.
- req[1] and req[2] pending together while NS leaves → EW served first, PED next, then NS.
- enable=0 in EW green → YELLOW 3, ALL_RED 2, FLASH (flash_o=1, remaining=0). enable=1 → all-red 2 ticks, then NS green.
- PREEMPT_EN: preempt=1 during PED walk at tick 2 → YELLOW next tick, then ALL_RED, NS grant held while preempt=1 with other requests pending.
